// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong types, coordinate widths and default geometry
package pong_pkg;

    localparam int Y_W     = 9;
    localparam int X_W     = 8;
    localparam int SCORE_W = 4;

    localparam int DEF_SIZE  = 10;
    localparam int DEF_MIN_Y = 10;
    localparam int DEF_MAX_Y = 310;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_POINT,
        ST_SERVE,
        ST_OVER
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                    input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? lim : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/serve_timer.sv
// rtl/serve_timer.sv - loadable strobe-gated down-counter with a zero flag
module serve_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong point scoring, serve sequencing and game-over control
// Rally counter is built only when SCORE_KEEPER_RALLY_EN is defined.
module score_keeper
    import pong_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int MIN_Y       = DEF_MIN_Y,
    parameter int MAX_Y       = DEF_MAX_Y,
    parameter int PADDLE_LEN  = 40,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ball_valid,
    input  logic [Y_W-1:0]     ball_y,
    input  logic [X_W-1:0]     ball_x,
    input  logic [Y_W-1:0]     player_1_x,
    input  logic [Y_W-1:0]     player_2_x,
    input  logic               start,
    output logic               ball_reset,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [7:0]         rally
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_score_1, r_score_2, w_score_1_nxt, w_score_2_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_ball_reset, w_ball_reset_nxt;
    logic               r_armed, w_armed_nxt;
    logic               w_load, w_zero;

    // 10-bit extended geometry so edge sums never wrap
    logic [9:0] w_y_lo, w_y_hi, w_x_lo, w_x_hi, w_p1_lo, w_p1_hi, w_p2_lo, w_p2_hi;
    logic       w_goal_1, w_goal_2, w_hit_1, w_hit_2;

    assign w_y_lo  = {1'b0, ball_y};
    assign w_y_hi  = w_y_lo + 10'(SIZE);
    assign w_x_lo  = {2'b00, ball_x};
    assign w_x_hi  = w_x_lo + 10'(SIZE - 1);
    assign w_p1_lo = {1'b0, player_1_x};
    assign w_p1_hi = w_p1_lo + 10'(PADDLE_LEN - 1);
    assign w_p2_lo = {1'b0, player_2_x};
    assign w_p2_hi = w_p2_lo + 10'(PADDLE_LEN - 1);

    assign w_goal_1 = (w_y_lo <= 10'(MIN_Y));
    assign w_goal_2 = (w_y_hi >= 10'(MAX_Y));
    assign w_hit_1  = w_goal_1 && (w_p1_lo <= w_x_hi) && (w_x_lo <= w_p1_hi);
    assign w_hit_2  = w_goal_2 && (w_p2_lo <= w_x_hi) && (w_x_lo <= w_p2_hi);

    serve_timer #(.W(8)) u_serve_timer (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (8'(SERVE_DELAY)),
        .i_dec      (ball_valid && (r_state == ST_POINT)),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SERVE;
            r_score_1    <= '0;
            r_score_2    <= '0;
            r_winner     <= WINNER_NONE;
            r_ball_reset <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_score_1    <= w_score_1_nxt;
            r_score_2    <= w_score_2_nxt;
            r_winner     <= w_winner_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_armed      <= w_armed_nxt;
        end
    end

    // r_armed blocks scoring on the first strobe after a serve
    always_comb begin
        w_state_nxt      = r_state;
        w_score_1_nxt    = r_score_1;
        w_score_2_nxt    = r_score_2;
        w_winner_nxt     = r_winner;
        w_armed_nxt      = r_armed;
        w_ball_reset_nxt = 1'b0;
        w_load           = 1'b0;
        case (r_state)
            ST_PLAY: if (ball_valid) begin
                w_armed_nxt = 1'b1;
                if (r_armed && w_goal_1 && !w_hit_1) begin
                    w_score_2_nxt = sat_inc(r_score_2, WIN);
                    if (w_score_2_nxt == WIN) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = WINNER_P2;
                    end else begin
                        w_state_nxt = ST_POINT;
                        w_load      = 1'b1;
                    end
                end else if (r_armed && !w_goal_1 && w_goal_2 && !w_hit_2) begin
                    w_score_1_nxt = sat_inc(r_score_1, WIN);
                    if (w_score_1_nxt == WIN) begin
                        w_state_nxt  = ST_OVER;
                        w_winner_nxt = WINNER_P1;
                    end else begin
                        w_state_nxt = ST_POINT;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_POINT: if (w_zero) w_state_nxt = ST_SERVE;
            ST_SERVE: begin
                w_ball_reset_nxt = 1'b1;
                w_armed_nxt      = 1'b0;
                w_state_nxt      = ST_PLAY;
            end
            ST_OVER: if (start) begin
                w_score_1_nxt = '0;
                w_score_2_nxt = '0;
                w_winner_nxt  = WINNER_NONE;
                w_state_nxt   = ST_SERVE;
            end
            default: w_state_nxt = ST_SERVE;
        endcase
    end

    assign ball_reset = r_ball_reset;
    assign score_1    = r_score_1;
    assign score_2    = r_score_2;
    assign winner     = r_winner;
    assign game_over  = (r_state == ST_OVER);

`ifdef SCORE_KEEPER_RALLY_EN
    logic [7:0] r_rally;
    logic       w_hit;

    assign w_hit = w_goal_1 ? w_hit_1 : w_hit_2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rally <= '0;
        end else if ((r_state == ST_SERVE) || ((r_state == ST_OVER) && start)) begin
            r_rally <= '0;
        end else if ((r_state == ST_PLAY) && ball_valid && w_hit && (r_rally != 8'hFF)) begin
            r_rally <= r_rally + 8'd1;
        end
    end

    assign rally = r_rally;
`else
    assign rally = '0;
`endif

endmodule
